// File: rtl/adder_arbiter_if.sv
// Bundle of the request/grant/result handshake and the adder operand/sum
// signals shared between the requesters, the arbiter and the ripple adder.
interface adder_arbiter_if;
   logic [3:0]  req;
   logic [19:0] op_a;
   logic [19:0] op_b;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic [5:0]  result;
   logic        busy;
   logic [4:0]  add_a;
   logic [4:0]  add_b;
   logic [5:0]  add_sum;

   // Requester/adder side: drives requests, operands and the adder sum.
   modport master (
      output req, op_a, op_b, add_sum,
      input  gnt, done, result, busy, add_a, add_b
   );

   // Arbiter side.
   modport slave (
      input  req, op_a, op_b, add_sum,
      output gnt, done, result, busy, add_a, add_b
   );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external 5-bit ripple adder among four
// requesters. Operands are launched from flops, held for SETTLE_CYCLES, then
// the 6-bit sum is captured and returned with a one-cycle done pulse.
module adder_arbiter #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   adder_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter is loaded with SETTLE_CYCLES-1 so the capture edge lands exactly
   // SETTLE_CYCLES edges after the operands were launched.
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t      state_q;
   logic [1:0]  ptr_q;
   logic [1:0]  winner_q;
   logic [3:0]  cnt_q;
   logic [3:0]  gnt_q;
   logic [3:0]  done_q;
   logic [5:0]  result_q;
   logic        busy_q;
   logic [4:0]  add_a_q;
   logic [4:0]  add_b_q;

   logic        pick_vld_s;
   logic [1:0]  pick_idx_s;
   logic [1:0]  cand_s;
   logic [4:0]  pick_a_s;
   logic [4:0]  pick_b_s;

   // Round-robin search: first set request at or above ptr, wrapping 3->0.
   // Scanning offsets high to low lets the smallest offset win last.
   always_comb begin
      pick_vld_s = 1'b0;
      pick_idx_s = ptr_q;
      cand_s     = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         cand_s = ptr_q + 2'(i);
         if (bus.req[cand_s]) begin
            pick_vld_s = 1'b1;
            pick_idx_s = cand_s;
         end else begin
            pick_vld_s = pick_vld_s;
         end
      end
   end

   // Select the winning requester's operand slices.
   always_comb begin
      pick_a_s = 5'd0;
      pick_b_s = 5'd0;
      case (pick_idx_s)
         2'd0: begin
            pick_a_s = bus.op_a[4:0];
            pick_b_s = bus.op_b[4:0];
         end
         2'd1: begin
            pick_a_s = bus.op_a[9:5];
            pick_b_s = bus.op_b[9:5];
         end
         2'd2: begin
            pick_a_s = bus.op_a[14:10];
            pick_b_s = bus.op_b[14:10];
         end
         2'd3: begin
            pick_a_s = bus.op_a[19:15];
            pick_b_s = bus.op_b[19:15];
         end
         default: begin
            pick_a_s = 5'd0;
            pick_b_s = 5'd0;
         end
      endcase
   end

   // Sequencer FSM with all outputs registered; reset drops any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 2'd0;
         winner_q <= 2'd0;
         cnt_q    <= 4'd0;
         gnt_q    <= 4'd0;
         done_q   <= 4'd0;
         result_q <= 6'd0;
         busy_q   <= 1'b0;
         add_a_q  <= 5'd0;
         add_b_q  <= 5'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_vld_s) begin
                  gnt_q    <= 4'(4'b0001 << pick_idx_s);
                  winner_q <= pick_idx_s;
                  add_a_q  <= pick_a_s;
                  add_b_q  <= pick_b_s;
                  cnt_q    <= CNT_LOAD;
                  busy_q   <= 1'b1;
                  state_q  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  result_q <= bus.add_sum;
                  done_q   <= gnt_q;
                  state_q  <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 4'd0;
               gnt_q   <= 4'd0;
               ptr_q   <= winner_q + 2'd1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done_q  <= 4'd0;
               gnt_q   <= 4'd0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.add_a  = add_a_q;
   assign bus.add_b  = add_b_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: randomized operands and request
// masks checked against a round-robin reference model in plain arithmetic.
module tb_adder_arbiter;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   adder_arbiter_if bus  ();
   adder_arbiter_if bus1 ();
   adder_arbiter_if bus5 ();

   adder_arbiter #(.SETTLE_CYCLES(2)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   adder_arbiter #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   adder_arbiter #(.SETTLE_CYCLES(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

   // External ripple adders.
   assign bus.add_sum  = {1'b0, bus.add_a}  + {1'b0, bus.add_b};
   assign bus1.add_sum = {1'b0, bus1.add_a} + {1'b0, bus1.add_b};
   assign bus5.add_sum = {1'b0, bus5.add_a} + {1'b0, bus5.add_b};

   int checks   = 0;
   int failures = 0;
   int model_ptr = 0;
   logic [4:0] opa [4];
   logic [4:0] opb [4];

   // Reference arbitration: first requester at or after ptr, wrapping.
   function automatic int rr_pick(input int ptr, input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         if (r[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   task automatic drive_ops();
      for (int k = 0; k < 4; k++) begin
         bus.op_a[k*5 +: 5] = opa[k];
         bus.op_b[k*5 +: 5] = opb[k];
      end
   endtask

   // Waits for a grant then the done pulse on the main DUT; returns observations.
   task automatic run_txn(output logic [3:0] g_o, output int lat_o, output logic [5:0] r_o,
                          output logic [3:0] d_o, output bit to_o, output bit held_o);
      logic [4:0] a0, b0;
      int n;
      g_o = 4'd0; lat_o = -1; r_o = 6'd0; d_o = 4'd0; to_o = 1'b1; held_o = 1'b1;
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1; n++;
         if (bus.gnt !== 4'd0) break;
      end
      if (bus.gnt === 4'd0) return;
      g_o = bus.gnt; a0 = bus.add_a; b0 = bus.add_b;
      n = 0;
      while (n < 40) begin
         if (bus.busy !== 1'b1 || bus.gnt !== g_o || bus.add_a !== a0 || bus.add_b !== b0) held_o = 1'b0;
         @(posedge clk); #1; n++;
         if (bus.done !== 4'd0) begin
            lat_o = n; r_o = bus.result; d_o = bus.done; to_o = 1'b0;
            break;
         end
      end
      if (!to_o && (bus.busy !== 1'b1 || bus.gnt !== g_o)) held_o = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (bus.gnt !== 4'd0) begin failures++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
      checks++; if (bus.done !== 4'd0) begin failures++; $display("FAIL reset_done got=%b want=0000", bus.done); end
      checks++; if (bus.result !== 6'd0) begin failures++; $display("FAIL reset_result got=%0d want=0", bus.result); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++; if (bus.add_a !== 5'd0 || bus.add_b !== 5'd0) begin failures++; $display("FAIL reset_add got=%0d/%0d want=0/0", bus.add_a, bus.add_b); end
   endtask

   task automatic test_single();
      logic [3:0] g, d; int lat; logic [5:0] r; bit to, held; int w;
      opa[0] = 5'd13; opb[0] = 5'd9; drive_ops();
      bus.req = 4'b0001;
      w = rr_pick(model_ptr, bus.req);
      run_txn(g, lat, r, d, to, held);
      bus.req = 4'd0;
      checks++; if (to) begin failures++; $display("FAIL single_timeout got=timeout want=done"); end
      checks++; if (g !== 4'(1 << w)) begin failures++; $display("FAIL single_gnt got=%b want=%b", g, 4'(1 << w)); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL single_latency got=%0d want=2", lat); end
      checks++; if (r !== 6'd22) begin failures++; $display("FAIL single_result got=%0d want=22", r); end
      checks++; if (d !== 4'b0001) begin failures++; $display("FAIL single_done got=%b want=0001", d); end
      checks++; if (!held) begin failures++; $display("FAIL single_hold got=unstable want=stable"); end
      model_ptr = (w + 1) % 4;
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'd0 || bus.done !== 4'd0) begin failures++; $display("FAIL single_idle got=busy%b gnt%b done%b want=0/0000/0000", bus.busy, bus.gnt, bus.done); end
      checks++; if (bus.result !== 6'd22) begin failures++; $display("FAIL single_result_hold got=%0d want=22", bus.result); end
   endtask

   task automatic test_max();
      logic [3:0] g, d; int lat; logic [5:0] r; bit to, held;
      for (int pass = 0; pass < 2; pass++) begin
         opa[2] = (pass == 0) ? 5'd31 : 5'd0;
         opb[2] = (pass == 0) ? 5'd31 : 5'd0;
         drive_ops();
         bus.req = 4'b0100;
         run_txn(g, lat, r, d, to, held);
         bus.req = 4'd0;
         checks++; if (g !== 4'b0100 || to) begin failures++; $display("FAIL max_gnt got=%b want=0100", g); end
         checks++; if (r !== ((pass == 0) ? 6'd62 : 6'd0)) begin failures++; $display("FAIL max_result got=%0d want=%0d", r, (pass == 0) ? 62 : 0); end
         model_ptr = 3;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_contention();
      logic [3:0] g, d; int lat; logic [5:0] r; bit to, held; int w; logic [5:0] exp;
      for (int k = 0; k < 4; k++) begin
         opa[k] = 5'($urandom_range(0, 31)); opb[k] = 5'($urandom_range(0, 31));
      end
      drive_ops();
      bus.req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         w = rr_pick(model_ptr, 4'b1111);
         exp = 6'(int'(opa[w]) + int'(opb[w]));
         run_txn(g, lat, r, d, to, held);
         checks++; if (to || g !== 4'(1 << w)) begin failures++; $display("FAIL contention_gnt[%0d] got=%b want=%b", i, g, 4'(1 << w)); end
         checks++; if (r !== exp || d !== g) begin failures++; $display("FAIL contention_result[%0d] got=%0d want=%0d", i, r, exp); end
         checks++; if (!held) begin failures++; $display("FAIL contention_hold[%0d] got=unstable want=stable", i); end
         model_ptr = (w + 1) % 4;
         // Operands of the served requester may change once granted.
         opa[w] = 5'($urandom_range(0, 31)); opb[w] = 5'($urandom_range(0, 31));
         drive_ops();
         if (i == 7) bus.req = 4'd0;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_fairness();
      logic [3:0] g, d; int lat; logic [5:0] r; bit to, held;
      opa[0] = 5'd4; opb[0] = 5'd5; opa[1] = 5'd10; opb[1] = 5'd11; drive_ops();
      bus.req = 4'b0010;
      run_txn(g, lat, r, d, to, held);
      bus.req = 4'd0;
      checks++; if (to || g !== 4'b0010) begin failures++; $display("FAIL fair_first got=%b want=0010", g); end
      model_ptr = 2;
      @(posedge clk); #1;
      bus.req = 4'b0011;
      run_txn(g, lat, r, d, to, held);
      bus.req = 4'b0010;
      checks++; if (to || g !== 4'(1 << rr_pick(model_ptr, 4'b0011))) begin failures++; $display("FAIL fair_req0 got=%b want=0001", g); end
      checks++; if (r !== 6'd9) begin failures++; $display("FAIL fair_req0_result got=%0d want=9", r); end
      model_ptr = 1;
      run_txn(g, lat, r, d, to, held);
      bus.req = 4'd0;
      checks++; if (to || g !== 4'b0010 || r !== 6'd21) begin failures++; $display("FAIL fair_req1 got=%b/%0d want=0010/21", g, r); end
      model_ptr = 2;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [3:0] g, d; int lat; logic [5:0] r; bit to, held; int w; logic [3:0] rq; logic [5:0] exp;
      for (int i = 0; i < 12; i++) begin
         for (int k = 0; k < 4; k++) begin
            opa[k] = 5'($urandom_range(0, 31)); opb[k] = 5'($urandom_range(0, 31));
         end
         drive_ops();
         rq = 4'($urandom_range(1, 15));
         bus.req = rq;
         w = rr_pick(model_ptr, rq);
         exp = 6'(int'(opa[w]) + int'(opb[w]));
         run_txn(g, lat, r, d, to, held);
         bus.req = 4'd0;
         checks++; if (to || g !== 4'(1 << w)) begin failures++; $display("FAIL random_gnt[%0d] req=%b got=%b want=%b", i, rq, g, 4'(1 << w)); end
         checks++; if (r !== exp || lat !== 2) begin failures++; $display("FAIL random_result[%0d] got=%0d lat=%0d want=%0d lat=2", i, r, lat, exp); end
         model_ptr = (w + 1) % 4;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_latency();
      int g1, d1, g5, d5; logic [5:0] r1, r5; bit stable;
      g1 = -1; d1 = -1; g5 = -1; d5 = -1; r1 = 6'd0; r5 = 6'd0; stable = 1'b1;
      bus1.op_a[14:10] = 5'd7; bus1.op_b[14:10] = 5'd20; bus1.req = 4'b0100;
      bus5.op_a[14:10] = 5'd7; bus5.op_b[14:10] = 5'd20; bus5.req = 4'b0100;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (g1 < 0 && bus1.gnt !== 4'd0) begin g1 = c; bus1.op_a[14:10] = 5'd3; end
         if (g5 < 0 && bus5.gnt !== 4'd0) begin g5 = c; bus5.op_a[14:10] = 5'd3; end
         if (d1 < 0 && bus1.done !== 4'd0) begin d1 = c; r1 = bus1.result; bus1.req = 4'd0; end
         if (d5 < 0 && bus5.done !== 4'd0) begin d5 = c; r5 = bus5.result; bus5.req = 4'd0; end
         if (bus1.busy === 1'b1 && (bus1.add_a !== 5'd7 || bus1.add_b !== 5'd20)) stable = 1'b0;
         if (bus5.busy === 1'b1 && (bus5.add_a !== 5'd7 || bus5.add_b !== 5'd20)) stable = 1'b0;
      end
      checks++; if (g1 < 0 || d1 - g1 !== 1) begin failures++; $display("FAIL latency_s1 got=%0d want=1", d1 - g1); end
      checks++; if (g5 < 0 || d5 - g5 !== 5) begin failures++; $display("FAIL latency_s5 got=%0d want=5", d5 - g5); end
      checks++; if (r1 !== 6'd27 || r5 !== 6'd27) begin failures++; $display("FAIL latency_result got=%0d/%0d want=27/27", r1, r5); end
      checks++; if (!stable) begin failures++; $display("FAIL latency_operand_hold got=unstable want=stable"); end
   endtask

   task automatic test_reset_midop();
      logic [3:0] g, d; int lat; logic [5:0] r; bit to, held, no_done; int n;
      opa[0] = 5'd5; opb[0] = 5'd6; drive_ops();
      bus.req = 4'b0001;
      n = 0;
      while (n < 40 && bus.gnt === 4'd0) begin @(posedge clk); #1; n++; end
      checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL midop_gnt got=%b want=0001", bus.gnt); end
      @(posedge clk); #1;
      bus.req = 4'd0;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.gnt !== 4'd0 || bus.done !== 4'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL midop_async got=gnt%b done%b busy%b want=0000/0000/0", bus.gnt, bus.done, bus.busy); end
      checks++; if (bus.result !== 6'd0 || bus.add_a !== 5'd0) begin failures++; $display("FAIL midop_result got=%0d/%0d want=0/0", bus.result, bus.add_a); end
      no_done = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (bus.done !== 4'd0) no_done = 1'b0;
      end
      rst_n = 1'b1;
      model_ptr = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (bus.done !== 4'd0) no_done = 1'b0;
      end
      checks++; if (!no_done) begin failures++; $display("FAIL midop_no_done got=pulse want=none"); end
      opa[3] = 5'd17; opb[3] = 5'd25; drive_ops();
      bus.req = 4'b1000;
      run_txn(g, lat, r, d, to, held);
      bus.req = 4'd0;
      checks++; if (to || g !== 4'(1 << rr_pick(model_ptr, 4'b1000))) begin failures++; $display("FAIL midop_wrap_gnt got=%b want=1000", g); end
      checks++; if (r !== 6'd42 || d !== 4'b1000) begin failures++; $display("FAIL midop_wrap_result got=%0d/%b want=42/1000", r, d); end
      @(posedge clk); #1;
   endtask

   // Hard stop should anything wedge the sequence.
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   // Test sequence.
   initial begin
      rst_n = 1'b0;
      bus.req = 4'd0;  bus.op_a = 20'd0;  bus.op_b = 20'd0;
      bus1.req = 4'd0; bus1.op_a = 20'd0; bus1.op_b = 20'd0;
      bus5.req = 4'd0; bus5.op_a = 20'd0; bus5.op_b = 20'd0;
      for (int k = 0; k < 4; k++) begin opa[k] = 5'd0; opb[k] = 5'd0; end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_single();
      test_max();
      test_contention();
      test_fairness();
      test_random();
      test_latency();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
